// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: serialises words from a first-word-fall-through FIFO onto a
// UART line (start bit, LSB-first data, optional even parity, one stop bit).
// The word is popped and latched on the single IDLE cycle between frames, so
// the FIFO may change freely while a frame is on the wire.

module fifo_uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 tx_next;
  logic                 bit_end;

  // State, counters, shift register and the registered serial line.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
    end
  end

  // Next-state logic; tx_next is the line level for the state being entered.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    tx_next     = 1'b1;
    fifo_rd_en  = 1'b0;
    frame_done  = 1'b0;
    busy        = (state != IDLE);
    bit_end     = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en  = 1'b1;
          shift_next  = fifo_data;
          parity_next = ^fifo_data;
          baud_next   = '0;
          bit_next    = '0;
          state_next  = START;
          tx_next     = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
          tx_next   = 1'b0;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + BIT_ONE;
            tx_next  = shift_next[0];
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
          tx_next   = shift_reg[0];
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
          tx_next   = parity_bit;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          baud_next  = '0;
          frame_done = 1'b1;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (rst) begin
      fifo_rd_en = 1'b0;
      frame_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed and randomised frames against two instances
// (parity off / parity on). Expected line levels come from a per-frame bit
// list built from the UART frame format, one entry per clock cycle.

module tb_fifo_uart_tx;

  localparam int CLKS  = 4;
  localparam int DBITS = 8;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       sel;

  logic fe0, rd0, tx0, busy0, fd0;
  logic fe1, rd1, tx1, busy1, fd1;
  logic obs_rd, obs_tx, obs_busy, obs_fd;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  // Free-running clock, 10 time-unit period.
  always #5 clk_in = ~clk_in;

  assign fe0 = sel ? 1'b1 : fifo_empty;
  assign fe1 = sel ? fifo_empty : 1'b1;

  assign obs_rd   = sel ? rd1   : rd0;
  assign obs_tx   = sel ? tx1   : tx0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_fd   = sel ? fd1   : fd0;

  fifo_uart_tx #(.DATA_BITS(DBITS), .CLKS_PER_BIT(CLKS), .PARITY_EN(0)) dut0 (
    .clk_in     (clk_in),
    .rst        (rst),
    .fifo_empty (fe0),
    .fifo_data  (fifo_data),
    .fifo_rd_en (rd0),
    .tx         (tx0),
    .busy       (busy0),
    .frame_done (fd0)
  );

  fifo_uart_tx #(.DATA_BITS(DBITS), .CLKS_PER_BIT(CLKS), .PARITY_EN(1)) dut1 (
    .clk_in     (clk_in),
    .rst        (rst),
    .fifo_empty (fe1),
    .fifo_data  (fifo_data),
    .fifo_rd_en (rd1),
    .tx         (tx1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Idle cycles with an empty FIFO: nothing may move.
  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      fifo_empty = 1'b1;
      #1;
      checkOutput($sformatf("idle%0d_rd_en", c), obs_rd, 1'b0);
      checkOutput($sformatf("idle%0d_busy", c), obs_busy, 1'b0);
      checkOutput($sformatf("idle%0d_frame_done", c), obs_fd, 1'b0);
      checkOutput($sformatf("idle%0d_tx", c), obs_tx, 1'b1);
    end
  endtask

  // Offers one word in the IDLE cycle and follows the whole frame cycle by
  // cycle. chain_next leaves the next word waiting at the end of the frame,
  // scramble wiggles the FIFO inputs mid-frame, abort_at>0 pulses rst on
  // that frame cycle.
  task automatic applyStimulus(input logic [7:0] word, input bit chain_next,
                               input logic [7:0] next_word, input bit scramble,
                               input int abort_at);
    int n;
    bit par;
    par = ($countones(word) % 2) == 1;
    exp_q = {};
    for (int i = 0; i < CLKS; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < DBITS; b++)
      for (int i = 0; i < CLKS; i++) exp_q.push_back(word[b]);
    if (sel)
      for (int i = 0; i < CLKS; i++) exp_q.push_back(par);
    for (int i = 0; i < CLKS; i++) exp_q.push_back(1'b1);
    n = exp_q.size();

    fifo_empty = 1'b0;
    fifo_data  = word;
    #1;
    checkOutput($sformatf("pop_rd_en_%h", word), obs_rd, 1'b1);
    checkOutput($sformatf("pop_tx_%h", word), obs_tx, 1'b1);
    checkOutput($sformatf("pop_busy_%h", word), obs_busy, 1'b0);

    for (int k = 1; k <= n; k++) begin
      @(negedge clk_in);
      if (k == abort_at) begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
      end else if (k == n || !scramble) begin
        fifo_empty = !chain_next;
        fifo_data  = next_word;
      end else begin
        fifo_empty = 1'($urandom_range(0, 1));
        fifo_data  = 8'($urandom);
      end
      #1;
      checkOutput($sformatf("w%h_c%0d_tx", word, k), obs_tx, exp_q[k-1]);
      checkOutput($sformatf("w%h_c%0d_busy", word, k), obs_busy, 1'b1);
      checkOutput($sformatf("w%h_c%0d_rd_en", word, k), obs_rd, 1'b0);
      checkOutput($sformatf("w%h_c%0d_frame_done", word, k), obs_fd, (k == n) && (k != abort_at));
      if (k == abort_at) break;
    end

    @(negedge clk_in);
    rst = 1'b0;
    #1;
    checkOutput($sformatf("w%h_gap_tx", word), obs_tx, 1'b1);
    checkOutput($sformatf("w%h_gap_busy", word), obs_busy, 1'b0);
    checkOutput($sformatf("w%h_gap_frame_done", word), obs_fd, 1'b0);
    checkOutput($sformatf("w%h_gap_rd_en", word), obs_rd, chain_next);
  endtask

  // Directed sequence followed by randomised frames.
  initial begin
    logic [7:0] w;
    logic       chain;

    sel        = 1'b0;
    rst        = 1'b1;
    fifo_empty = 1'b0;
    fifo_data  = 8'hA5;
    @(posedge clk_in);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      #1;
      checkOutput("rst_tx0", tx0, 1'b1);
      checkOutput("rst_busy0", busy0, 1'b0);
      checkOutput("rst_rd_en0", rd0, 1'b0);
      checkOutput("rst_frame_done0", fd0, 1'b0);
      checkOutput("rst_tx1", tx1, 1'b1);
      checkOutput("rst_busy1", busy1, 1'b0);
      checkOutput("rst_rd_en1", rd1, 1'b0);
      checkOutput("rst_frame_done1", fd1, 1'b0);
    end
    @(negedge clk_in);
    rst = 1'b0;

    $display("[TB] single byte A5 popped straight out of reset");
    applyStimulus(8'hA5, 1'b0, 8'h00, 1'b0, 0);

    $display("[TB] back-to-back 00 then FF");
    applyStimulus(8'h00, 1'b1, 8'hFF, 1'b0, 0);
    applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 0);

    $display("[TB] empty FIFO for 100 cycles");
    idleCycles(100);

    $display("[TB] parity instance: 07 and 03");
    sel = 1'b1;
    applyStimulus(8'h07, 1'b0, 8'h00, 1'b0, 0);
    applyStimulus(8'h03, 1'b0, 8'h00, 1'b0, 0);

    $display("[TB] reset during data bit 3 of 55");
    sel = 1'b0;
    applyStimulus(8'h55, 1'b0, 8'h00, 1'b0, 1 + CLKS + 3 * CLKS + 1);
    idleCycles(30);

    $display("[TB] random frames with FIFO inputs changing mid-frame");
    for (int f = 0; f < 8; f++) begin
      sel   = 1'($urandom_range(0, 1));
      w     = 8'($urandom);
      chain = 1'b0;
      applyStimulus(w, chain, 8'h00, 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, giving the payload bits per frame and the FIFO word width.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 217, giving clk_in cycles per serial bit (25 MHz / 115200); legal range is 2 or more.
REQ-003 The module SHALL have parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted after the data bits.
REQ-004 The module SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port fifo_empty, input, 1 bit: upstream FIFO has no data.
REQ-007 The module SHALL have port fifo_data, input, DATA_BITS wide: the FIFO head word, valid whenever fifo_empty=0 (first-word-fall-through).
REQ-008 The module SHALL have port fifo_rd_en, output, 1 bit: a one-cycle pop strobe to the FIFO.
REQ-009 The module SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY_EN=0.
REQ-013 In IDLE with fifo_empty=0, the block SHALL assert fifo_rd_en for exactly that cycle, capture fifo_data into the shift register, compute even parity of it, and enter START next cycle.
REQ-014 In IDLE with fifo_empty=1, the block SHALL hold tx=1, busy=0 and fifo_rd_en=0.
REQ-015 fifo_rd_en SHALL only be asserted in IDLE with fifo_empty=0, never more than one cycle per frame, and never when fifo_empty=1.
REQ-016 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every bit boundary.
REQ-017 tx SHALL be registered and take these values: START drives 0; DATA drives the shift register LSB first, shifting right at each bit boundary; PARITY drives the captured parity; STOP drives 1.
REQ-018 A bit counter SHALL count DATA bits from 0 to DATA_BITS-1, then the FSM leaves DATA.
REQ-019 busy SHALL be 1 from the cycle after the pop through the last STOP cycle, inclusive.
REQ-020 After the last STOP cycle the FSM SHALL return to IDLE, so consecutive frames are separated by exactly one IDLE cycle (the pop cycle), during which tx=1.
REQ-021 Total cycles from the pop to the next possible pop SHALL be 1 + CLKS_PER_BIT*(DATA_BITS+2+PARITY_EN).
REQ-022 Changes on fifo_empty or fifo_data outside IDLE SHALL NOT affect the frame in progress.
REQ-023 Counters SHALL be sized with $clog2 of their maximum value and SHALL never wrap within a bit or frame.

Reset
REQ-024 While rst=1 at a rising clk_in edge, the block SHALL go to IDLE and set tx=1, busy=0, fifo_rd_en=0 and frame_done=0, with all counters and the shift register cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame: tx returns to 1 on the cycle after the reset edge, and the popped word is discarded (no re-pop).
REQ-026 In the first cycle after rst deasserts, a non-empty FIFO SHALL be popped immediately.

Verification (bench: CLKS_PER_BIT=4, DATA_BITS=8)
REQ-027 Bench SHALL cover single byte 0xA5 with PARITY_EN=0 -> one fifo_rd_en pulse; tx holds 0 (start) for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 (stop) for 4 cycles; frame_done pulses on cycle 40 after the pop.
REQ-028 Bench SHALL cover back-to-back bytes 0x00 and 0xFF preloaded -> second fifo_rd_en occurs exactly 41 cycles after the first; tx is high for exactly 1 cycle between frames.
REQ-029 Bench SHALL cover PARITY_EN=1 with 0x07 -> parity bit is 1 and the frame is 44 cycles; with 0x03 -> parity bit is 0.
REQ-030 Bench SHALL cover fifo_empty held high for 100 cycles -> fifo_rd_en, busy and frame_done stay 0 and tx stays 1.
REQ-031 Bench SHALL cover rst pulsed during DATA bit 3 of 0x55 with the FIFO then empty -> tx=1 and busy=0 the next cycle, and no further fifo_rd_en.
REQ-032 Bench SHALL cover fifo_data changed mid-frame -> the transmitted bits match the word captured at the pop.
